// File: rtl/uart_rx_deserializer.sv
// UART receiver: 16x-oversampled frame of start, 8 data bits LSB-first, even parity, stop.
// Optional build macro UART_RX_MAJORITY_EN: 2-of-3 majority sampling at ticks 6/7/8.

module baud_controller (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] baud_select,
    output logic       sample_enable
);
    logic [13:0] limit;
    logic [13:0] count;

    // Clocks per 16x sample tick at a 50 MHz system clock.
    always_comb begin
        case (baud_select)
            3'd0:    limit = 14'd10417;
            3'd1:    limit = 14'd2604;
            3'd2:    limit = 14'd651;
            3'd3:    limit = 14'd326;
            3'd4:    limit = 14'd163;
            3'd5:    limit = 14'd81;
            3'd6:    limit = 14'd54;
            default: limit = 14'd27;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count         <= '0;
            sample_enable <= 1'b0;
        end else if (count >= limit - 14'd1) begin
            count         <= '0;
            sample_enable <= 1'b1;
        end else begin
            count         <= count + 14'd1;
            sample_enable <= 1'b0;
        end
    end
endmodule

module uart_rx_deserializer #(
    parameter int DATA_W = 8,
    parameter int OVS    = 16,
    parameter int MID    = 7
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [2:0]        baud_select,
    input  logic              RX_EN,
    input  logic              RxD,
    output logic [DATA_W-1:0] Rx_DATA,
    output logic              Rx_VALID,
    output logic              Rx_PERROR,
    output logic              Rx_FERROR
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    localparam logic [3:0] MID_TICK  = 4'(MID);
    localparam logic [3:0] LAST_TICK = 4'(OVS - 1);
    localparam logic [2:0] LAST_BIT  = 3'(DATA_W - 1);

    state_t            state;
    logic [3:0]        tick_cnt;
    logic [2:0]        bit_idx;
    logic [DATA_W-1:0] shift;
    logic [1:0]        rxd_sync;
    logic              rxd_s;
    logic              tick;
    logic              sample;
    logic              done;

    baud_controller u_baud (
        .clock         (clock),
        .reset         (reset),
        .baud_select   (baud_select),
        .sample_enable (tick)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) rxd_sync <= 2'b11;
        else       rxd_sync <= {rxd_sync[0], RxD};
    end
    assign rxd_s = rxd_sync[1];

`ifdef UART_RX_MAJORITY_EN
    localparam logic [3:0] ACT_TICK = MID_TICK + 4'd1;
    logic [1:0] early;

    // Holds the samples taken at the two ticks preceding the action tick.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            early <= 2'b11;
        end else if (tick && state != IDLE &&
                     (tick_cnt == MID_TICK - 4'd1 || tick_cnt == MID_TICK)) begin
            early <= {early[0], rxd_s};
        end
    end
    assign sample = (early[1] & early[0]) | (early[1] & rxd_s) | (early[0] & rxd_s);
`else
    localparam logic [3:0] ACT_TICK = MID_TICK;
    assign sample = rxd_s;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            done      <= 1'b0;
            Rx_DATA   <= '0;
            Rx_VALID  <= 1'b0;
            Rx_PERROR <= 1'b0;
            Rx_FERROR <= 1'b0;
        end else begin
            done     <= 1'b0;
            // Flags were written together with done, so they are current here.
            Rx_VALID <= done & ~Rx_PERROR & ~Rx_FERROR;
            if (!RX_EN && state != IDLE) begin
                state <= IDLE;
            end else if (tick) begin
                tick_cnt <= tick_cnt + 4'd1;
                case (state)
                    IDLE: begin
                        if (RX_EN && !rxd_s) begin
                            state     <= START;
                            tick_cnt  <= '0;
                            Rx_PERROR <= 1'b0;
                            Rx_FERROR <= 1'b0;
                        end
                    end
                    START: begin
                        if (tick_cnt == ACT_TICK && sample) begin
                            state <= IDLE;
                        end else if (tick_cnt == LAST_TICK) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end
                    end
                    DATA: begin
                        if (tick_cnt == ACT_TICK) shift[bit_idx] <= sample;
                        if (tick_cnt == LAST_TICK) begin
                            if (bit_idx == LAST_BIT) state <= PARITY;
                            else                     bit_idx <= bit_idx + 3'd1;
                        end
                    end
                    PARITY: begin
                        if (tick_cnt == ACT_TICK)  Rx_PERROR <= sample ^ (^shift);
                        if (tick_cnt == LAST_TICK) state <= STOP;
                    end
                    STOP: begin
                        // Leaving at mid-stop lets the next start edge be caught immediately.
                        if (tick_cnt == ACT_TICK) begin
                            Rx_FERROR <= ~sample;
                            Rx_DATA   <= shift;
                            done      <= 1'b1;
                            state     <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Self-checking bench for uart_rx_deserializer: tick-aligned serial driver, frame-level reference model.
module tb_uart_rx_deserializer;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] baud_select = 3'd7;
    logic       RX_EN = 1'b1;
    logic       RxD = 1'b1;
    logic [7:0] Rx_DATA;
    logic       Rx_VALID;
    logic       Rx_PERROR;
    logic       Rx_FERROR;

    int checks = 0;
    int failures = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    wire tick_obs = dut.tick;

    uart_rx_deserializer dut (
        .clock       (clock),
        .reset       (reset),
        .baud_select (baud_select),
        .RX_EN       (RX_EN),
        .RxD         (RxD),
        .Rx_DATA     (Rx_DATA),
        .Rx_VALID    (Rx_VALID),
        .Rx_PERROR   (Rx_PERROR),
        .Rx_FERROR   (Rx_FERROR)
    );

    always #5 clock = ~clock;

    // Every clock with Rx_VALID high delivers one byte.
    always @(negedge clock) begin
        if (Rx_VALID === 1'b1) got_q.push_back(Rx_DATA);
    end

    // Reference: what the receiver should report for one frame as put on the wire.
    task automatic model_frame(input logic [7:0] d, input logic par, input logic stop,
                               input logic glitch, output logic [7:0] rd,
                               output logic pe, output logic fe);
        rd = d;
`ifndef UART_RX_MAJORITY_EN
        if (glitch) rd[0] = 1'b0;
`endif
        pe = (par != ^rd);
        fe = !stop;
    endtask

    task automatic wait_tick();
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (tick_obs !== 1'b1 && n < 100);
        if (tick_obs !== 1'b1) begin
            $display("FAIL tick_timeout got=no_tick_in_%0d_clocks exp=tick", n);
            $fatal(1, "sample tick missing");
        end
    endtask

    task automatic drive_ticks(input logic v, input int n);
        RxD = v;
        repeat (n) wait_tick();
    endtask

    // Starts right after a tick; each bit is held for 16 ticks.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                              input logic glitch);
        drive_ticks(1'b0, 16);
        if (glitch) begin
            drive_ticks(d[0], 8);
            drive_ticks(1'b0, 1);
            drive_ticks(d[0], 7);
        end else begin
            drive_ticks(d[0], 16);
        end
        for (int i = 1; i < 8; i++) drive_ticks(d[i], 16);
        drive_ticks(par, 16);
        if (stop) begin
            drive_ticks(1'b1, 16);
        end else begin
            drive_ticks(1'b0, 9);
            drive_ticks(1'b1, 7);
        end
        RxD = 1'b1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        checks++; if (Rx_DATA !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", Rx_DATA); end
        checks++; if (Rx_VALID !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", Rx_VALID); end
        checks++; if (Rx_PERROR !== 1'b0) begin failures++; $display("FAIL reset_perror got=%b exp=0", Rx_PERROR); end
        checks++; if (Rx_FERROR !== 1'b0) begin failures++; $display("FAIL reset_ferror got=%b exp=0", Rx_FERROR); end
        reset = 1'b0;
        wait_tick();
    endtask

    task automatic test_good_frame();
        logic [7:0] ed; logic ep, ef; int n0, nv;
        model_frame(8'hA5, 1'b0, 1'b1, 1'b0, ed, ep, ef);
        n0 = got_q.size();
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
        nv = got_q.size() - n0;
        checks++; if (Rx_DATA !== ed) begin failures++; $display("FAIL good_data got=%h exp=%h", Rx_DATA, ed); end
        checks++; if (Rx_PERROR !== ep) begin failures++; $display("FAIL good_perror got=%b exp=%b", Rx_PERROR, ep); end
        checks++; if (Rx_FERROR !== ef) begin failures++; $display("FAIL good_ferror got=%b exp=%b", Rx_FERROR, ef); end
        checks++; if (nv !== 1) begin failures++; $display("FAIL good_valid_cycles got=%0d exp=1", nv); end
        if (nv > 0) begin
            checks++; if (got_q[$] !== ed) begin failures++; $display("FAIL good_valid_data got=%h exp=%h", got_q[$], ed); end
        end
    endtask

    task automatic test_false_start();
        logic [7:0] prev; int n0, nv;
        prev = Rx_DATA;
        n0 = got_q.size();
        drive_ticks(1'b0, 4);
        drive_ticks(1'b1, 20);
        nv = got_q.size() - n0;
        checks++; if (Rx_DATA !== prev) begin failures++; $display("FAIL false_start_data got=%h exp=%h", Rx_DATA, prev); end
        checks++; if (nv !== 0) begin failures++; $display("FAIL false_start_valid got=%0d exp=0", nv); end
        checks++; if ({Rx_PERROR, Rx_FERROR} !== 2'b00) begin failures++; $display("FAIL false_start_flags got=%b%b exp=00", Rx_PERROR, Rx_FERROR); end
    endtask

    task automatic test_rx_en_abort();
        logic [7:0] prev, d, ed; logic ep, ef; int n0, nv;
        prev = Rx_DATA;
        d = 8'h55;
        n0 = got_q.size();
        drive_ticks(1'b0, 16);
        for (int i = 0; i < 3; i++) drive_ticks(d[i], 16);
        drive_ticks(d[3], 8);
        RX_EN = 1'b0;
        drive_ticks(1'b1, 24);
        RX_EN = 1'b1;
        drive_ticks(1'b1, 4);
        nv = got_q.size() - n0;
        checks++; if (Rx_DATA !== prev) begin failures++; $display("FAIL abort_data got=%h exp=%h", Rx_DATA, prev); end
        checks++; if (nv !== 0) begin failures++; $display("FAIL abort_valid got=%0d exp=0", nv); end
        checks++; if ({Rx_PERROR, Rx_FERROR} !== 2'b00) begin failures++; $display("FAIL abort_flags got=%b%b exp=00", Rx_PERROR, Rx_FERROR); end
        model_frame(8'hF0, 1'b0, 1'b1, 1'b0, ed, ep, ef);
        n0 = got_q.size();
        send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
        nv = got_q.size() - n0;
        checks++; if (Rx_DATA !== ed) begin failures++; $display("FAIL after_abort_data got=%h exp=%h", Rx_DATA, ed); end
        checks++; if (nv !== 1) begin failures++; $display("FAIL after_abort_valid got=%0d exp=1", nv); end
    endtask

    task automatic test_parity_error();
        logic [7:0] ed; logic ep, ef; int n0, nv;
        model_frame(8'h3C, 1'b1, 1'b1, 1'b0, ed, ep, ef);
        n0 = got_q.size();
        send_frame(8'h3C, 1'b1, 1'b1, 1'b0);
        nv = got_q.size() - n0;
        checks++; if (Rx_DATA !== ed) begin failures++; $display("FAIL perr_data got=%h exp=%h", Rx_DATA, ed); end
        checks++; if (Rx_PERROR !== ep) begin failures++; $display("FAIL perr_flag got=%b exp=%b", Rx_PERROR, ep); end
        checks++; if (nv !== 0) begin failures++; $display("FAIL perr_valid got=%0d exp=0", nv); end
        model_frame(8'h01, 1'b1, 1'b1, 1'b0, ed, ep, ef);
        n0 = got_q.size();
        send_frame(8'h01, 1'b1, 1'b1, 1'b0);
        nv = got_q.size() - n0;
        checks++; if (Rx_DATA !== ed) begin failures++; $display("FAIL perr_next_data got=%h exp=%h", Rx_DATA, ed); end
        checks++; if (Rx_PERROR !== ep) begin failures++; $display("FAIL perr_clear got=%b exp=%b", Rx_PERROR, ep); end
        checks++; if (nv !== 1) begin failures++; $display("FAIL perr_next_valid got=%0d exp=1", nv); end
    endtask

    task automatic test_framing_error();
        logic [7:0] ed; logic ep, ef; int n0, nv;
        model_frame(8'h7E, 1'b0, 1'b0, 1'b0, ed, ep, ef);
        n0 = got_q.size();
        send_frame(8'h7E, 1'b0, 1'b0, 1'b0);
        nv = got_q.size() - n0;
        checks++; if (Rx_DATA !== ed) begin failures++; $display("FAIL ferr_data got=%h exp=%h", Rx_DATA, ed); end
        checks++; if (Rx_FERROR !== ef) begin failures++; $display("FAIL ferr_flag got=%b exp=%b", Rx_FERROR, ef); end
        checks++; if (Rx_PERROR !== ep) begin failures++; $display("FAIL ferr_perror got=%b exp=%b", Rx_PERROR, ep); end
        checks++; if (nv !== 0) begin failures++; $display("FAIL ferr_valid got=%0d exp=0", nv); end
    endtask

    task automatic test_glitch();
        logic [7:0] ed; logic ep, ef; int n0, nv, ev;
        model_frame(8'h81, 1'b0, 1'b1, 1'b1, ed, ep, ef);
        ev = (ep || ef) ? 0 : 1;
        n0 = got_q.size();
        send_frame(8'h81, 1'b0, 1'b1, 1'b1);
        nv = got_q.size() - n0;
        checks++; if (Rx_DATA !== ed) begin failures++; $display("FAIL glitch_data got=%h exp=%h", Rx_DATA, ed); end
        checks++; if (Rx_PERROR !== ep) begin failures++; $display("FAIL glitch_perror got=%b exp=%b", Rx_PERROR, ep); end
        checks++; if (nv !== ev) begin failures++; $display("FAIL glitch_valid got=%0d exp=%0d", nv, ev); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d, ed; logic ep, ef; int n0, nv;
        d = 8'($urandom_range(1, 255));
        send_frame(d, ~(^d), 1'b1, 1'b0);
        drive_ticks(1'b0, 16);
        drive_ticks(1'b1, 5);
        reset = 1'b1;
        #1;
        checks++; if (Rx_DATA !== 8'h00) begin failures++; $display("FAIL midreset_data got=%h exp=00", Rx_DATA); end
        checks++; if (Rx_PERROR !== 1'b0) begin failures++; $display("FAIL midreset_perror got=%b exp=0", Rx_PERROR); end
        checks++; if ({Rx_VALID, Rx_FERROR} !== 2'b00) begin failures++; $display("FAIL midreset_valid_ferror got=%b%b exp=00", Rx_VALID, Rx_FERROR); end
        repeat (3) @(negedge clock);
        reset = 1'b0;
        n0 = got_q.size();
        wait_tick();
        drive_ticks(1'b1, 30);
        nv = got_q.size() - n0;
        checks++; if (Rx_DATA !== 8'h00) begin failures++; $display("FAIL postreset_idle_data got=%h exp=00", Rx_DATA); end
        checks++; if (nv !== 0) begin failures++; $display("FAIL postreset_idle_valid got=%0d exp=0", nv); end
        d = 8'($urandom);
        model_frame(d, ^d, 1'b1, 1'b0, ed, ep, ef);
        n0 = got_q.size();
        send_frame(d, ^d, 1'b1, 1'b0);
        nv = got_q.size() - n0;
        checks++; if (Rx_DATA !== ed) begin failures++; $display("FAIL postreset_data got=%h exp=%h", Rx_DATA, ed); end
        checks++; if (nv !== 1) begin failures++; $display("FAIL postreset_valid got=%0d exp=1", nv); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d, ed; logic par, stop, ep, ef; int kind;
        got_q.delete();
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            d = 8'($urandom);
            kind = $urandom_range(0, 3);
            par = (^d) ^ (kind == 0);
            stop = (kind != 1);
            model_frame(d, par, stop, 1'b0, ed, ep, ef);
            if (!ep && !ef) exp_q.push_back(ed);
            send_frame(d, par, stop, 1'b0);
            checks++; if (Rx_DATA !== ed) begin failures++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, Rx_DATA, ed); end
            checks++; if ({Rx_PERROR, Rx_FERROR} !== {ep, ef}) begin failures++; $display("FAIL b2b_flags[%0d] got=%b%b exp=%b%b", i, Rx_PERROR, Rx_FERROR, ep, ef); end
        end
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL b2b_valid_count got=%0d exp=%0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL b2b_valid_byte[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_false_start();
        test_rx_en_abort();
        test_parity_error();
        test_framing_error();
        test_glitch();
        test_reset_mid_frame();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
